// File: rtl/superio_irqctl_pkg.sv
// Shared register map, bit positions and helpers for the SuperIO interrupt controller.
package superio_irq_pkg;

  localparam int NSRC_MAX = 16;

  typedef logic [15:0] reg_addr_t;

  localparam reg_addr_t REG_PEND_L   = 16'd0;
  localparam reg_addr_t REG_PEND_H   = 16'd1;
  localparam reg_addr_t REG_MASK_L   = 16'd2;
  localparam reg_addr_t REG_MASK_H   = 16'd3;
  localparam reg_addr_t REG_MODE_L   = 16'd4;
  localparam reg_addr_t REG_MODE_H   = 16'd5;
  localparam reg_addr_t REG_CTRL     = 16'd6;
  localparam reg_addr_t REG_VECTOR   = 16'd7;
  localparam reg_addr_t REG_RAW_L    = 16'd8;
  localparam reg_addr_t REG_RAW_H    = 16'd9;
  localparam reg_addr_t REG_SWTRIG_L = 16'd10;
  localparam reg_addr_t REG_SWTRIG_H = 16'd11;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_IRQ_BIT  = 7;
  localparam int VEC_VALID_BIT = 7;

  // Source i lives in the L register of a pair for i < 8, otherwise in the H register.
  function automatic reg_addr_t byte_addr(input reg_addr_t base, input int i);
    return (i < 8) ? base : base + reg_addr_t'(1);
  endfunction

endpackage

// File: rtl/superio_irqctl_if.sv
// SuperIO slave register bus: address, write data, read data, direction and chip select.
interface superio_irqctl_if #(
  parameter int AW = 4
);
  logic [AW-1:0] AD;
  logic [7:0]    DI;
  logic [7:0]    DO;
  logic          rw;
  logic          cs;

  modport master (output AD, DI, rw, cs, input DO);
  modport slave  (input AD, DI, rw, cs, output DO);
endinterface

// File: rtl/superio_irqctl_prio.sv
// Combinational priority encoder: lowest set index of req, plus a valid flag.
module superio_irq_prio #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output logic [3:0]      idx,
  output logic            valid
);

  // Scanning downwards lets the lowest set index be the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/superio_irqctl.sv
// Interrupt controller for the SuperIO bus: per-source mask and level/edge mode, one registered irq.
// Define SUPERIO_IRQCTL_SWTRIG_EN to add the write-only software trigger registers at 10/11.
module superio_irqctl
  import superio_irq_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int AW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  superio_irqctl_if.slave bus,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] prev;
  logic            ctrl_en;

  logic [AW-1:0]   addr;
  reg_addr_t       reg_sel;
  logic            wr_en;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] mask_nxt;
  logic [NSRC-1:0] mode_nxt;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] sw_set;
  logic [NSRC-1:0] pend_nxt;
  logic [3:0]      vec_idx;
  logic            vec_valid;
  logic [15:0]     pend_w;
  logic [15:0]     mask_w;
  logic [15:0]     mode_w;
  logic [15:0]     raw_w;

  assign addr    = bus.AD;
  assign reg_sel = reg_addr_t'(addr);
  assign wr_en   = bus.cs & ~bus.rw;
  assign rise    = src & ~prev;
  assign active  = pending & mask;

  superio_irq_prio #(.NSRC(NSRC)) u_prio (
    .req   (active),
    .idx   (vec_idx),
    .valid (vec_valid)
  );

  // Per-source view of this cycle's bus write; out-of-range bits simply do not exist.
  always_comb begin
    mask_nxt = mask;
    mode_nxt = mode;
    pend_clr = '0;
    sw_set   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (wr_en && reg_sel == byte_addr(REG_MASK_L, i)) mask_nxt[i] = bus.DI[i[2:0]];
      if (wr_en && reg_sel == byte_addr(REG_MODE_L, i)) mode_nxt[i] = bus.DI[i[2:0]];
      if (wr_en && reg_sel == byte_addr(REG_PEND_L, i)) pend_clr[i] = bus.DI[i[2:0]];
`ifdef SUPERIO_IRQCTL_SWTRIG_EN
      if (wr_en && reg_sel == byte_addr(REG_SWTRIG_L, i)) sw_set[i] = bus.DI[i[2:0]];
`endif
    end
  end

  // A mode flip discards the bit; otherwise new edges and triggers beat a same-cycle clear.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (mode_nxt[i] != mode[i])
        pend_nxt[i] = 1'b0;
      else if (mode[i])
        pend_nxt[i] = rise[i] | sw_set[i] | (pending[i] & ~pend_clr[i]);
      else
        pend_nxt[i] = src[i] | sw_set[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      prev    <= '0;
      ctrl_en <= 1'b0;
      irq     <= 1'b0;
    end else begin
      prev    <= src;
      pending <= pend_nxt;
      mask    <= mask_nxt;
      mode    <= mode_nxt;
      if (wr_en && reg_sel == REG_CTRL) ctrl_en <= bus.DI[CTRL_EN_BIT];
      irq     <= ctrl_en & vec_valid;
    end
  end

  assign pend_w = 16'(pending);
  assign mask_w = 16'(mask);
  assign mode_w = 16'(mode);
  assign raw_w  = 16'(src);

  // Read data decodes straight from AD; unmapped and write-only addresses read 0.
  always_comb begin
    bus.DO = '0;
    case (reg_sel)
      REG_PEND_L: bus.DO = pend_w[7:0];
      REG_PEND_H: bus.DO = pend_w[15:8];
      REG_MASK_L: bus.DO = mask_w[7:0];
      REG_MASK_H: bus.DO = mask_w[15:8];
      REG_MODE_L: bus.DO = mode_w[7:0];
      REG_MODE_H: bus.DO = mode_w[15:8];
      REG_CTRL: begin
        bus.DO[CTRL_IRQ_BIT] = irq;
        bus.DO[CTRL_EN_BIT]  = ctrl_en;
      end
      REG_VECTOR: begin
        bus.DO[VEC_VALID_BIT] = vec_valid;
        bus.DO[3:0]           = vec_idx;
      end
      REG_RAW_L:  bus.DO = raw_w[7:0];
      REG_RAW_H:  bus.DO = raw_w[15:8];
      default:    bus.DO = '0;
    endcase
  end

endmodule
